// File: rtl/spi_debug_loader.sv
// Command decoder behind the SPI slave: loads instruction memory, runs/steps/stops the
// MIPS core and returns status, PC or register words for the next SPI transfer.
module spi_debug_loader #(
    parameter int NB_BITS    = 32,
    parameter int NB_ADDR    = 10,
    parameter int NB_REG_SEL = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NB_BITS-1:0]    i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_halt,
    input  logic [NB_BITS-1:0]    i_pc,
    input  logic [NB_BITS-1:0]    i_reg_data,
    output logic [NB_BITS-1:0]    o_tx_data,
    output logic                  o_imem_we,
    output logic [NB_ADDR-1:0]    o_imem_addr,
    output logic [NB_BITS-1:0]    o_imem_data,
    output logic                  o_cpu_en,
    output logic                  o_cpu_rst,
    output logic [NB_REG_SEL-1:0] o_reg_sel,
    output logic                  o_busy
);
    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_LOAD   = 8'h01;
    localparam logic [7:0] OP_RUN    = 8'h02;
    localparam logic [7:0] OP_STEP   = 8'h03;
    localparam logic [7:0] OP_STOP   = 8'h04;
    localparam logic [7:0] OP_RDREG  = 8'h05;
    localparam logic [7:0] OP_RDPC   = 8'h06;
    localparam logic [7:0] OP_CPURST = 8'h07;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_READ} state_t;

    function automatic logic [NB_BITS-1:0] status_word(input logic running, input logic halted);
        return {8'hA5, 7'b0, running, halted, 15'b0};
    endfunction

    state_t                state_q, state_d;
    logic [NB_ADDR-1:0]    cnt_q, cnt_d;
    logic [NB_ADDR-1:0]    addr_q, addr_d;
    logic                  halted_q, halted_d;
    logic [NB_BITS-1:0]    tx_q, tx_d;
    logic                  we_q, we_d;
    logic [NB_ADDR-1:0]    imem_addr_q, imem_addr_d;
    logic [NB_BITS-1:0]    imem_data_q, imem_data_d;
    logic                  cpu_en_q, cpu_en_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic [NB_REG_SEL-1:0] reg_sel_q, reg_sel_d;
    logic                  busy_q, busy_d;

    logic [7:0]            opcode;
    logic [NB_ADDR-1:0]    arg;
    logic [NB_BITS-1:0]    error_word;

    assign opcode     = i_rx_data[NB_BITS-1 -: 8];
    assign arg        = i_rx_data[NB_ADDR-1:0];
    assign error_word = {8'hEE, 16'h0, opcode};

    // Pulses (we, cpu_rst) and cpu_en default low so they only last one cycle unless held.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        halted_d    = halted_q;
        tx_d        = tx_q;
        we_d        = 1'b0;
        imem_addr_d = imem_addr_q;
        imem_data_d = imem_data_q;
        cpu_en_d    = 1'b0;
        cpu_rst_d   = 1'b0;
        reg_sel_d   = reg_sel_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    case (opcode)
                        OP_NOP: tx_d = status_word(1'b0, halted_q);
                        OP_LOAD: begin
                            if (arg == '0) begin
                                tx_d = status_word(1'b0, halted_q);
                            end else begin
                                cnt_d   = arg;
                                addr_d  = '0;
                                busy_d  = 1'b1;
                                state_d = ST_LOAD;
                            end
                        end
                        OP_RUN: begin
                            cpu_en_d = 1'b1;
                            halted_d = 1'b0;
                            tx_d     = status_word(1'b1, 1'b0);
                            state_d  = ST_RUN;
                        end
                        OP_STEP: cpu_en_d = 1'b1;
                        OP_RDREG: begin
                            reg_sel_d = i_rx_data[NB_REG_SEL-1:0];
                            state_d   = ST_READ;
                        end
                        OP_RDPC: tx_d = i_pc;
                        OP_CPURST: begin
                            cpu_rst_d = 1'b1;
                            halted_d  = 1'b0;
                        end
                        default: tx_d = error_word;
                    endcase
                end
            end
            ST_LOAD: begin
                if (i_rx_valid) begin
                    we_d        = 1'b1;
                    imem_addr_d = addr_q;
                    imem_data_d = i_rx_data;
                    addr_d      = addr_q + NB_ADDR'(1);
                    cnt_d       = cnt_q - NB_ADDR'(1);
                    if (cnt_q == NB_ADDR'(1)) begin
                        busy_d  = 1'b0;
                        tx_d    = status_word(1'b0, halted_q);
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RUN: begin
                // A halt drops any word strobed in the same cycle.
                if (i_halt) begin
                    halted_d = 1'b1;
                    tx_d     = status_word(1'b0, 1'b1);
                    state_d  = ST_IDLE;
                end else begin
                    cpu_en_d = 1'b1;
                    if (i_rx_valid) begin
                        case (opcode)
                            OP_STOP: begin
                                cpu_en_d = 1'b0;
                                state_d  = ST_IDLE;
                            end
                            OP_RDPC: tx_d = i_pc;
                            default: tx_d = error_word;
                        endcase
                    end
                end
            end
            ST_READ: begin
                tx_d    = i_reg_data;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            halted_q    <= 1'b0;
            tx_q        <= status_word(1'b0, 1'b0);
            we_q        <= 1'b0;
            imem_addr_q <= '0;
            imem_data_q <= '0;
            cpu_en_q    <= 1'b0;
            cpu_rst_q   <= 1'b0;
            reg_sel_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            halted_q    <= halted_d;
            tx_q        <= tx_d;
            we_q        <= we_d;
            imem_addr_q <= imem_addr_d;
            imem_data_q <= imem_data_d;
            cpu_en_q    <= cpu_en_d;
            cpu_rst_q   <= cpu_rst_d;
            reg_sel_q   <= reg_sel_d;
            busy_q      <= busy_d;
        end
    end

    assign o_tx_data   = tx_q;
    assign o_imem_we   = we_q;
    assign o_imem_addr = imem_addr_q;
    assign o_imem_data = imem_data_q;
    assign o_cpu_en    = cpu_en_q;
    assign o_cpu_rst   = cpu_rst_q;
    assign o_reg_sel   = reg_sel_q;
    assign o_busy      = busy_q;
endmodule

// File: tb/tb_spi_debug_loader.sv
// Bench for spi_debug_loader: a command-level model predicts each cycle's outputs and
// instruction-memory writes; a monitor pops the expectations and compares them.
module tb_spi_debug_loader;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [31:0] i_rx_data = '0;
  logic        i_rx_valid = 1'b0;
  logic        i_halt = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] i_reg_data;
  logic [31:0] o_tx_data;
  logic        o_imem_we;
  logic [9:0]  o_imem_addr;
  logic [31:0] o_imem_data;
  logic        o_cpu_en;
  logic        o_cpu_rst;
  logic [4:0]  o_reg_sel;
  logic        o_busy;

  logic [31:0] regs [32];
  assign i_reg_data = regs[o_reg_sel];

  spi_debug_loader dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
    .i_halt(i_halt), .i_pc(i_pc), .i_reg_data(i_reg_data), .o_tx_data(o_tx_data),
    .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_data(o_imem_data),
    .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst), .o_reg_sel(o_reg_sel), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          due;
    logic [31:0] tx;
    bit          cpu_en;
    bit          busy;
    bit          cpu_rst;
    logic [4:0]  sel;
  } chk_t;
  typedef struct {
    int          due;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  chk_t exp_q[$];
  wr_t  wr_q[$];
  int   ncyc = 0;
  int   total = 0;
  int   bad = 0;

  // command-level reference model
  bit          m_running, m_halted, m_read_pending;
  int          m_left;
  logic [9:0]  m_addr;
  logic [4:0]  m_sel;
  logic [31:0] m_tx;

  function automatic logic [31:0] status(input bit r, input bit h);
    return {8'hA5, 7'b0, r, h, 15'b0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, ncyc, act, exp);
    end
  endtask

  // monitor: compares DUT outputs against the expectation queues
  initial begin
    forever begin
      @(negedge i_clk);
      ncyc++;
      if (o_imem_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_we", 32'd1, 32'd0);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("we_cycle", ncyc, w.due);
          chk("imem_addr", {22'b0, o_imem_addr}, {22'b0, w.addr});
          chk("imem_data", o_imem_data, w.data);
        end
      end
      while (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
        chk_t c;
        c = exp_q.pop_front();
        chk("exp_on_time", ncyc, c.due);
        chk("tx_data", o_tx_data, c.tx);
        chk("cpu_en", {31'b0, o_cpu_en}, {31'b0, c.cpu_en});
        chk("busy", {31'b0, o_busy}, {31'b0, c.busy});
        chk("cpu_rst", {31'b0, o_cpu_rst}, {31'b0, c.cpu_rst});
        chk("reg_sel", {27'b0, o_reg_sel}, {27'b0, c.sel});
      end
    end
  end

  task automatic push_exp(input bit step, input bit rst_pulse);
    chk_t c;
    c.due = ncyc + 1;
    c.tx = m_tx;
    c.cpu_en = m_running | step;
    c.busy = (m_left > 0);
    c.cpu_rst = rst_pulse;
    c.sel = m_sel;
    exp_q.push_back(c);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #1;
    i_rst = 1'b1;
    i_rx_valid = 1'b0;
    i_halt = 1'b0;
    m_running = 0; m_halted = 0; m_read_pending = 0;
    m_left = 0; m_addr = '0; m_sel = '0;
    m_tx = 32'hA500_0000;
    push_exp(0, 0);
  endtask

  task automatic drive_cycle(input bit v, input logic [31:0] d, input bit h, input logic [31:0] pc);
    bit step, rp;
    logic [7:0] op;
    @(negedge i_clk);
    #1;
    i_rst = 1'b0;
    i_rx_valid = v;
    i_rx_data = d;
    i_halt = h;
    i_pc = pc;
    step = 0; rp = 0;
    op = d[31:24];
    if (m_read_pending) begin
      m_tx = regs[m_sel];
      m_read_pending = 0;
    end else if (m_left > 0) begin
      if (v) begin
        wr_q.push_back('{ncyc + 1, m_addr, d});
        m_addr = m_addr + 10'd1;
        m_left--;
        if (m_left == 0) m_tx = status(0, m_halted);
      end
    end else if (m_running) begin
      if (h) begin
        m_running = 0;
        m_halted = 1;
        m_tx = status(0, 1);
      end else if (v) begin
        if (op == 8'h04) m_running = 0;
        else if (op == 8'h06) m_tx = pc;
        else m_tx = {8'hEE, 16'h0, op};
      end
    end else if (v) begin
      case (op)
        8'h00: m_tx = status(0, m_halted);
        8'h01: begin
          if (d[9:0] == 10'd0) m_tx = status(0, m_halted);
          else begin
            m_left = int'(d[9:0]);
            m_addr = '0;
          end
        end
        8'h02: begin
          m_running = 1;
          m_halted = 0;
          m_tx = status(1, 0);
        end
        8'h03: step = 1;
        8'h05: begin
          m_sel = d[4:0];
          m_read_pending = 1;
        end
        8'h06: m_tx = pc;
        8'h07: begin
          rp = 1;
          m_halted = 0;
        end
        default: m_tx = {8'hEE, 16'h0, op};
      endcase
    end
    push_exp(step, rp);
  endtask

  task automatic strobe(input logic [31:0] d);
    drive_cycle(1, d, 0, $urandom);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, $urandom, 0, $urandom);
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [7:0] op;
    logic [31:0] w;
    int pick;
    pick = $urandom_range(0, 11);
    op = (pick <= 7) ? 8'(pick) : 8'($urandom_range(8, 255));
    w = {op, 8'($urandom), 16'($urandom)};
    if (op == 8'h01) w[9:0] = 10'($urandom_range(0, 4));
    return w;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[7] = 32'hDEAD_BEEF;

    do_reset();
    strobe(32'h0000_0000);
    idle(1);
    // load three words
    strobe(32'h0100_0003);
    strobe(32'h0000_0011);
    strobe(32'h0000_0022);
    idle(1);
    strobe(32'h0000_0033);
    idle(2);
    // run, then halt
    strobe(32'h0200_0000);
    idle(3);
    drive_cycle(0, '0, 1, $urandom);
    idle(2);
    // step, read pc, read register
    strobe(32'h0300_0000);
    idle(2);
    drive_cycle(1, 32'h0600_0000, 0, 32'h0000_0040);
    idle(1);
    strobe(32'h0500_0007);
    idle(3);
    // run with rdpc, bad opcode and stop
    strobe(32'h0200_0000);
    drive_cycle(1, 32'h0600_0000, 0, 32'h0000_1234);
    strobe(32'h0000_0000);
    strobe(32'h0400_0000);
    idle(2);
    // cpu reset, empty load
    strobe(32'h0700_0000);
    idle(1);
    strobe(32'h0100_0000);
    idle(1);
    // reset in the middle of a load
    strobe(32'h0100_0002);
    strobe(32'hCAFE_0001);
    do_reset();
    strobe(32'h0000_0000);
    idle(1);
    strobe(32'h9C00_0000);
    idle(2);
    // halt coinciding with a strobe while running
    strobe(32'h0200_0000);
    drive_cycle(1, 32'h0600_0000, 1, 32'h0000_0077);
    idle(2);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit v, h;
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        v = m_read_pending ? 1'b0 : ($urandom_range(0, 2) != 0);
        h = m_running && ($urandom_range(0, 11) == 0);
        if (m_left > 0) drive_cycle(v, $urandom, h, $urandom);
        else drive_cycle(v, rand_cmd(), h, $urandom);
      end
    end
    idle(4);
    @(negedge i_clk);
    #2;
    chk("exp_queue_drained", exp_q.size(), 0);
    chk("writes_all_seen", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
